// File: rtl/uabc_scroll_display.sv
// uabc_scroll_display
// Scrolling "UABC-ELECTRONICA" driver for common-anode, active-low
// 7-segment displays. Time-multiplexes NUM_DIGITS digits and scrolls the
// message right-to-left. The message enters through a blank lead-in window.
// Optional build macro: SCROLL_ONESHOT_EN
//   Defined:   one full pass, then the display parks in DONE until activar drops.
//   Undefined: scrolling repeats for as long as activar stays high.
module uabc_scroll_display #(
   parameter int NUM_DIGITS = 4,
   parameter int MSG_LEN    = 16,
   parameter int SCAN_DIV   = 5000,
   parameter int SCROLL_DIV = 250
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        activar,
   output logic [6:0]                                  seg,
   output logic [NUM_DIGITS-1:0]                       an,
   output logic                                        pulso,
   output logic                                        wrap,
   output logic [$clog2(MSG_LEN+NUM_DIGITS)-1:0]       offset
);

   localparam int L  = NUM_DIGITS + MSG_LEN;
   localparam int OW = $clog2(L);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] SCROLL_MAX = CW'(SCROLL_DIV - 1);
   localparam logic [DW-1:0] DIG_MAX    = DW'(NUM_DIGITS - 1);
   localparam logic [OW-1:0] OFF_MAX    = OW'(L - 1);
   localparam logic [OW:0]   L_W        = (OW+1)'(L);
   localparam logic [OW:0]   ND_W       = (OW+1)'(NUM_DIGITS);

`ifdef SCROLL_ONESHOT_EN
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

   state_t          state, state_n;
   logic            act_m, act_s;
   logic [SW-1:0]   scan_cnt, scan_n;
   logic [CW-1:0]   scroll_cnt, scroll_n;
   logic [DW-1:0]   digit_idx, idx_n;
   logic [OW-1:0]   offset_n;
   logic            pulso_n, wrap_n, tick;
   logic [OW:0]     sum_pos, tape_pos;
   logic [3:0]      rom_k, char_code;
   logic [6:0]      seg_n;
   logic [NUM_DIGITS-1:0] an_n;

   // Message ROM: character codes for "UABC-ELECTRONICA"
   function automatic logic [3:0] rom_char(input logic [3:0] k);
      case (k)
         4'd0:  return 4'd1;   // U
         4'd1:  return 4'd2;   // A
         4'd2:  return 4'd3;   // B
         4'd3:  return 4'd4;   // C
         4'd4:  return 4'd5;   // -
         4'd5:  return 4'd6;   // E
         4'd6:  return 4'd7;   // L
         4'd7:  return 4'd6;   // E
         4'd8:  return 4'd4;   // C
         4'd9:  return 4'd8;   // T
         4'd10: return 4'd9;   // R
         4'd11: return 4'd10;  // O
         4'd12: return 4'd11;  // N
         4'd13: return 4'd12;  // I
         4'd14: return 4'd4;   // C
         default: return 4'd2; // A
      endcase
   endfunction

   // Character code to active-low {g,f,e,d,c,b,a}; unused codes stay blank
   function automatic logic [6:0] font(input logic [3:0] c);
      case (c)
         4'd1:  return 7'b1000001;
         4'd2:  return 7'b0001000;
         4'd3:  return 7'b0000011;
         4'd4:  return 7'b1000110;
         4'd5:  return 7'b0111111;
         4'd6:  return 7'b0000110;
         4'd7:  return 7'b1000111;
         4'd8:  return 7'b1001110;
         4'd9:  return 7'b0101111;
         4'd10: return 7'b1000000;
         4'd11: return 7'b0101011;
         4'd12: return 7'b1001111;
         default: return 7'b1111111;
      endcase
   endfunction

   // Two-flop synchronizer for the asynchronous run enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_m <= 1'b0;
         act_s <= 1'b0;
      end else begin
         act_m <= activar;
         act_s <= act_m;
      end
   end

   // Next-state logic: scan/scroll counters, digit index, offset and pulses
   always_comb begin
      state_n  = state;
      scan_n   = '0;
      scroll_n = scroll_cnt;
      idx_n    = digit_idx;
      offset_n = offset;
      pulso_n  = pulso;
      wrap_n   = 1'b0;
      tick     = 1'b0;
      case (state)
         IDLE: begin
            scroll_n = '0;
            idx_n    = '0;
            offset_n = '0;
            if (act_s) state_n = RUN;
         end
         RUN: begin
            tick   = (scan_cnt == SCAN_MAX);
            scan_n = tick ? '0 : scan_cnt + 1'b1;
            if (tick) begin
               pulso_n = ~pulso;
               idx_n   = (digit_idx == '0) ? DIG_MAX : digit_idx - 1'b1;
               if (scroll_cnt == SCROLL_MAX) begin
                  scroll_n = '0;
                  if (offset == OFF_MAX) begin
                     offset_n = '0;
                     wrap_n   = 1'b1;
`ifdef SCROLL_ONESHOT_EN
                     state_n  = DONE;
`endif
                  end else begin
                     offset_n = offset + 1'b1;
                  end
               end else begin
                  scroll_n = scroll_cnt + 1'b1;
               end
            end
            if (!act_s) begin
               state_n  = IDLE;
               scan_n   = '0;
               scroll_n = '0;
               idx_n    = '0;
               offset_n = '0;
               wrap_n   = 1'b0;
            end
         end
`ifdef SCROLL_ONESHOT_EN
         DONE: begin
            scan_n = scan_cnt;
            if (!act_s) state_n = IDLE;
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   // Display lookup from the post-update index and offset so no stale frame appears
   always_comb begin
      sum_pos   = {1'b0, offset_n} + (OW+1)'(DIG_MAX - idx_n);
      tape_pos  = (sum_pos >= L_W) ? sum_pos - L_W : sum_pos;
      rom_k     = 4'(tape_pos - ND_W);
      char_code = (tape_pos < ND_W) ? 4'd0 : rom_char(rom_k);
      an_n      = '1;
      seg_n     = 7'h7F;
      if (state_n == RUN) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            an_n[i] = (idx_n != DW'(i));
         end
         seg_n = font(char_code);
      end
   end

   // State, counters and registered display outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         scan_cnt   <= '0;
         scroll_cnt <= '0;
         digit_idx  <= '0;
         offset     <= '0;
         pulso      <= 1'b0;
         wrap       <= 1'b0;
         seg        <= 7'h7F;
         an         <= '1;
      end else begin
         state      <= state_n;
         scan_cnt   <= scan_n;
         scroll_cnt <= scroll_n;
         digit_idx  <= idx_n;
         offset     <= offset_n;
         pulso      <= pulso_n;
         wrap       <= wrap_n;
         seg        <= seg_n;
         an         <= an_n;
      end
   end

endmodule
